clk_div_duty_shaper: RTL and testbench

- Downstream stage of the fractional clock divider.
- Consumes the divider's one-cycle-wide period pulse, which is dual-modulus, e.g. 9/8/9/8/9 cycles for 8.6.
- Measures each pulse interval and regenerates a near-50% duty output in the source clock domain.
- Reports the measured period, a lock status and sticky error flags for the downstream clocking/enable logic.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_period_meter.sv | 43 ++++
 rtl/clk_div_duty_shaper.sv | 127 ++++++++++++
 tb/tb_clk_div_duty_shaper.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the fractional-divider duty shaper.
// The optional averaging mode (SHAPER_AVG_EN) only changes what callers pass as p_prev.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    RUN
  } shaper_state_t;

  localparam int DEF_CNT_W = 8;

  // High time from a summed period pair; passing p_prev == p yields max(1, p>>1).
  function automatic logic [31:0] calc_high(input logic [31:0] p, input logic [31:0] p_prev);
    logic [32:0] sum;
    logic [31:0] h;
    sum = {1'b0, p} + {1'b0, p_prev};
    h   = 32'(sum >> 2);
    return (h == 32'd0) ? 32'd1 : h;
  endfunction

endpackage

// File: rtl/clk_div_period_meter.sv
// Interval meter for the duty shaper: saturating cycle counter between divider
// pulses, period capture (P = cnt+1, clamped) and the period/period_vld report.
module clk_div_period_meter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pulse_in,
  input  logic             active,
  output logic [CNT_W-1:0] p_meas,
  output logic             sat,
  output logic [CNT_W-1:0] period,
  output logic             period_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  assign sat    = (cnt == CNT_MAX);
  assign p_meas = sat_inc(cnt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= pulse_in & active;
      if (pulse_in && active) period <= p_meas;
      // IDLE holds the counter at zero; every pulse restarts the interval.
      if (!active || pulse_in) cnt <= '0;
      else                     cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/clk_div_duty_shaper.sv
// Regenerates a near-50% duty clock from the dual-modulus divider pulse.
// Define SHAPER_AVG_EN to derive the high time from the average of the last two periods.
module clk_div_duty_shaper
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LOCK_CNT   = 2,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pulse_in,
  input  logic             err_clr,
  output logic             clk_out,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err_short,
  output logic             err_timeout
);

  shaper_state_t    state;
  logic [3:0]       good_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] p_meas;
  logic [CNT_W-1:0] p_hist;
  logic [CNT_W-1:0] h_load;
  logic             sat;
  logic             active;
  logic             short_evt;
  logic             tmo_evt;

  assign active    = (state != IDLE);
  assign short_evt = active && pulse_in && (p_meas < CNT_W'(MIN_PERIOD));
  assign tmo_evt   = active && sat && !pulse_in;

  clk_div_period_meter #(
    .CNT_W (CNT_W)
  ) u_meter (
    .clk        (clk),
    .rstn       (rstn),
    .pulse_in   (pulse_in),
    .active     (active),
    .p_meas     (p_meas),
    .sat        (sat),
    .period     (period),
    .period_vld (period_vld)
  );

`ifdef SHAPER_AVG_EN
  logic [CNT_W-1:0] p_prev;

  // History is meaningful only in RUN; IDLE and short periods wipe it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           p_prev <= '0;
    else if (state == IDLE || short_evt) p_prev <= '0;
    else if (pulse_in)                   p_prev <= p_meas;
  end
`endif

  always_comb begin
    p_hist = p_meas;
`ifdef SHAPER_AVG_EN
    if (state == RUN) p_hist = p_prev;
`endif
    h_load = CNT_W'(calc_high(32'(p_meas), 32'(p_hist)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      good_cnt    <= '0;
      high_cnt    <= '0;
      clk_out     <= 1'b0;
      locked      <= 1'b0;
      err_short   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // A new error outranks a simultaneous clear.
      err_short   <= (err_short & ~err_clr) | short_evt;
      err_timeout <= (err_timeout & ~err_clr) | tmo_evt;
      case (state)
        IDLE: begin
          clk_out  <= 1'b0;
          locked   <= 1'b0;
          high_cnt <= '0;
          good_cnt <= '0;
          if (pulse_in) state <= ACQ;
        end
        ACQ: begin
          if (tmo_evt) begin
            state    <= IDLE;
            good_cnt <= '0;
          end else if (short_evt) begin
            good_cnt <= '0;
          end else if (pulse_in) begin
            good_cnt <= good_cnt + 4'd1;
            if (good_cnt == 4'(LOCK_CNT - 1)) begin
              state    <= RUN;
              locked   <= 1'b1;
              high_cnt <= h_load;
              clk_out  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (tmo_evt || short_evt) begin
            state    <= tmo_evt ? IDLE : ACQ;
            locked   <= 1'b0;
            clk_out  <= 1'b0;
            high_cnt <= '0;
            good_cnt <= '0;
          end else if (pulse_in) begin
            // Reload even mid-high so a shrinking period never glitches low.
            high_cnt <= h_load;
            clk_out  <= 1'b1;
          end else if (high_cnt != '0) begin
            high_cnt <= high_cnt - CNT_W'(1);
            if (high_cnt == CNT_W'(1)) clk_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_duty_shaper.sv
// Directed bench for clk_div_duty_shaper (default build, CNT_W=8, LOCK_CNT=2, MIN_PERIOD=2).
module tb_clk_div_duty_shaper;

  logic       clk;
  logic       rstn;
  logic       pulse_in;
  logic       err_clr;
  logic       clk_out;
  logic [7:0] period;
  logic       period_vld;
  logic       locked;
  logic       err_short;
  logic       err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  clk_div_duty_shaper #(
    .CNT_W      (8),
    .LOCK_CNT   (2),
    .MIN_PERIOD (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pulse_in    (pulse_in),
    .err_clr     (err_clr),
    .clk_out     (clk_out),
    .period      (period),
    .period_vld  (period_vld),
    .locked      (locked),
    .err_short   (err_short),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_h(input int p);
    int h;
    h = p / 2;
    return (h < 1) ? 1 : h;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge, strobed periods checked against the scoreboard.
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (period_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_period_vld", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("period", 32'(period), 32'(e));
      end
    end
  endtask

  // Pulse now, then let n cycles elapse before the next pulse may be driven.
  task automatic pulse_period(input int n, input bit exp_vld, input int exp_p,
                              output int hi, output bit contig);
    bit seen_low;
    if (exp_vld) sb.push_back(exp_p);
    pulse_in = 1'b1;
    tick();
    check("period_vld", 32'(period_vld), 32'(exp_vld));
    pulse_in = 1'b0;
    hi       = 0;
    contig   = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (clk_out === 1'b1) begin
        hi++;
        if (seen_low) contig = 1'b0;
      end else begin
        seen_low = 1'b1;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_period_vld"}, 32'(period_vld), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err_short"}, 32'(err_short), 32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int hi;
    bit c;
    int prev;
    int dm[5] = '{8, 9, 8, 9, 9};

    rstn     = 1'b0;
    pulse_in = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Steady 9-cycle pulses: acquire and lock on the third pulse.
    pulse_period(9, 1'b0, 0, hi, c);
    check("p1_locked", 32'(locked), 32'd0);
    check("p1_high", 32'(hi), 32'd0);
    pulse_period(9, 1'b1, 9, hi, c);
    check("p2_locked", 32'(locked), 32'd0);
    pulse_period(9, 1'b1, 9, hi, c);
    check("p3_locked", 32'(locked), 32'd1);
    check("p3_high", 32'(hi), 32'd4);
    check("p3_contig", 32'(c), 32'd1);
    pulse_period(9, 1'b1, 9, hi, c);
    check("p4_high", 32'(hi), 32'd4);

    // Dual-modulus: reported periods 9,8,9,8,9.
    prev = 9;
    for (int k = 0; k < 5; k++) begin
      pulse_period(dm[k], 1'b1, prev, hi, c);
      check("dm_high", 32'(hi), 32'(exp_h(prev)));
      check("dm_contig", 32'(c), 32'd1);
      check("dm_locked", 32'(locked), 32'd1);
      prev = dm[k];
    end

    // Adjacent pulses in RUN, with err_clr in the same cycle as the short error.
    pulse_period(1, 1'b1, 9, hi, c);
    check("pre_short_high", 32'(hi), 32'd1);
    sb.push_back(1);
    pulse_in = 1'b1;
    err_clr  = 1'b1;
    tick();
    pulse_in = 1'b0;
    err_clr  = 1'b0;
    check("short_vld", 32'(period_vld), 32'd1);
    check("short_err", 32'(err_short), 32'd1);
    check("short_locked", 32'(locked), 32'd0);
    check("short_clk_out", 32'(clk_out), 32'd0);
    repeat (8) tick();
    pulse_period(9, 1'b1, 9, hi, c);
    check("relock1_locked", 32'(locked), 32'd0);
    check("relock1_high", 32'(hi), 32'd0);
    pulse_period(9, 1'b1, 9, hi, c);
    check("relock2_locked", 32'(locked), 32'd1);
    check("relock2_high", 32'(hi), 32'd4);
    check("short_sticky", 32'(err_short), 32'd1);

    // Period shrink 20 -> 4: reload mid-high without a low glitch.
    pulse_period(20, 1'b1, 9, hi, c);
    check("shrink_a_high", 32'(hi), 32'd4);
    pulse_period(4, 1'b1, 20, hi, c);
    check("shrink_b_high", 32'(hi), 32'd4);
    pulse_period(9, 1'b1, 4, hi, c);
    check("shrink_c_high", 32'(hi), 32'd2);
    check("shrink_c_contig", 32'(c), 32'd1);

    // Timeout: last pulse 9 samples ago; counter saturates 256 cycles after it.
    repeat (247) tick();
    check("pre_timeout", 32'(err_timeout), 32'd0);
    tick();
    check("timeout_err", 32'(err_timeout), 32'd1);
    check("timeout_locked", 32'(locked), 32'd0);
    check("timeout_clk_out", 32'(clk_out), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_timeout", 32'(err_timeout), 32'd0);
    check("clr_short", 32'(err_short), 32'd0);

    // Restart acquisition, then reset in the middle of the first high phase.
    pulse_period(9, 1'b0, 0, hi, c);
    check("reacq1_locked", 32'(locked), 32'd0);
    pulse_period(9, 1'b1, 9, hi, c);
    check("reacq2_locked", 32'(locked), 32'd0);
    pulse_period(2, 1'b1, 9, hi, c);
    check("reacq3_locked", 32'(locked), 32'd1);
    check("reacq3_high", 32'(hi), 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("sb_empty_rst", 32'(sb.size()), 32'd0);
    tick();
    tick();
    rstn = 1'b1;

    // After release: no strobe on first pulse; a pulse at saturation is clamped, no timeout.
    pulse_period(9, 1'b0, 0, hi, c);
    check("post_rst_locked", 32'(locked), 32'd0);
    pulse_period(256, 1'b1, 9, hi, c);
    check("sat_pre_timeout", 32'(err_timeout), 32'd0);
    pulse_period(9, 1'b1, 255, hi, c);
    check("sat_timeout", 32'(err_timeout), 32'd0);
    check("sat_locked", 32'(locked), 32'd1);
    check("sat_high", 32'(hi), 32'd9);
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
